// File: rtl/sipo_word_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_word_assembler_pkg
// Brief    : Shared FSM encodings, defaults and clog2 helper for the SIPO
//            word assembler.
// Revision : 1.0 - initial release
// ============================================================================
package sipo_word_assembler_pkg;

    localparam int c_DEFAULT_WORD_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_word_assembler_if.sv
`default_nettype none
// ============================================================================
// Module   : sipo_word_assembler_if
// Brief    : Valid/ready word channel from the assembler to its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface sipo_word_assembler_if
    import sipo_word_assembler_pkg::*;
#(
    parameter int WORD_W = c_DEFAULT_WORD_W
);
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_out, output word_valid, input word_ready);
    modport slave  (input word_out, input word_valid, output word_ready);
endinterface
`default_nettype wire

// File: rtl/sipo_word_assembler_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sipo_fifo
// Brief    : Show-ahead synchronous FIFO with level output; head reads 0 when
//            empty. A push into a full FIFO succeeds only alongside a pop.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_fifo
    import sipo_word_assembler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset_b,
    input  wire logic                 i_push,
    input  wire logic [WIDTH-1:0]     i_push_data,
    input  wire logic                 i_pop,
    output logic      [WIDTH-1:0]     o_head_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic      [clog2(DEPTH):0] o_level
);
    localparam int            c_AW    = clog2(DEPTH);
    localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == c_DEPTH);
    assign o_empty   = (r_level == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_data = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level     = r_level;

endmodule
`default_nettype wire

// File: rtl/sipo_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : sipo_word_assembler
// Brief    : Assembles serial ADC bits into WORD_W-bit words, buffers them in a
//            FIFO and reports overflow, abort and a saturating word count.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_word_assembler
    import sipo_word_assembler_pkg::*;
#(
    parameter int WORD_W     = c_DEFAULT_WORD_W,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  wire logic                        clk,
    input  wire logic                        reset_b,
    input  wire logic                        data_logging,
    input  wire logic                        serial_in,
    input  wire logic                        clear_status,
    sipo_word_assembler_if.master            out_if,
    output logic                             overflow,
    output logic                             abort,
    output logic      [CNT_W-1:0]            word_count,
    output logic      [clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int               c_BW       = clog2(WORD_W);
    localparam logic [c_BW-1:0]  c_LAST_BIT = c_BW'(WORD_W - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_abort_evt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_shift_next;
    logic [c_BW-1:0]   r_bit_cnt;
    logic              w_word_done;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_overflow_evt;
    logic              r_overflow;
    logic              r_abort;
    logic [CNT_W-1:0]  r_word_count;

    if (MSB_FIRST) begin : g_msb_first
        assign w_shift_next = {r_shift[WORD_W-2:0], serial_in};
    end else begin : g_lsb_first
        assign w_shift_next = {serial_in, r_shift[WORD_W-1:1]};
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_abort_evt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (data_logging) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!data_logging) begin
                    w_state_next = ST_IDLE;
                    w_abort_evt  = (r_bit_cnt != '0);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (data_logging) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= (r_bit_cnt == c_LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
        end else if (w_abort_evt) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end
    end

    // A completed word still lands in a full FIFO if the consumer pops this cycle.
    assign w_word_done    = data_logging && (r_bit_cnt == c_LAST_BIT);
    assign w_pop          = !w_fifo_empty && out_if.word_ready;
    assign w_push_ok      = w_word_done && (!w_fifo_full || w_pop);
    assign w_overflow_evt = w_word_done && w_fifo_full && !w_pop;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_overflow   <= 1'b0;
            r_abort      <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_overflow <= (r_overflow && !clear_status) || w_overflow_evt;
            r_abort    <= (r_abort && !clear_status) || w_abort_evt;
            if (clear_status) begin
                r_word_count <= w_push_ok ? CNT_W'(1) : '0;
            end else if (w_push_ok && (r_word_count != c_CNT_MAX)) begin
                r_word_count <= r_word_count + 1'b1;
            end
        end
    end

    sipo_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk         (clk),
        .reset_b     (reset_b),
        .i_push      (w_word_done),
        .i_push_data (w_shift_next),
        .i_pop       (w_pop),
        .o_head_data (out_if.word_out),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_level     (fifo_level)
    );

    assign out_if.word_valid = !w_fifo_empty;
    assign overflow          = r_overflow;
    assign abort             = r_abort;
    assign word_count        = r_word_count;

endmodule
`default_nettype wire

// File: doc/sipo_word_assembler.md
Name: sipo_word_assembler

Overview:
- Downstream datapath stage of the SIPO controller.
- While the controller holds data_logging high, it samples one serial acoustic-ADC bit per clock and assembles the bits into WORD_W-bit parallel words.
- Completed words are buffered in a small FIFO and offered to the consumer (logger/DMA) over a valid/ready handshake.
- Reports dropped words, aborted partial words and a running word count.

Parameters:
- WORD_W, 16, bits per assembled word (2..32).
- MSB_FIRST, 1, 1 = first serial bit lands in word bit WORD_W-1; 0 = first bit lands in bit 0.
- FIFO_DEPTH, 4, output buffer entries (power of two, >= 2).
- CNT_W, 8, width of saturating word counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_b  input  1  asynchronous active-low reset.
- data_logging  input  1  from SIPO controller; high = sample serial_in this cycle.
- serial_in  input  1  serial data bit, valid whenever data_logging is high.
- clear_status  input  1  synchronous single-cycle clear of overflow, abort and word_count.
- word_out  output  WORD_W  head-of-FIFO word.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  consumer accepts word_out when word_valid and word_ready are both high.
- overflow  output  1  sticky: a completed word was dropped because the FIFO was full.
- abort  output  1  sticky: data_logging fell with a partial word in progress.
- word_count  output  CNT_W  words successfully pushed since reset/clear; saturates at all-ones.
- fifo_level  output  log2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, reset_b=0):
  - shift register and bit_cnt are 0; FSM is IDLE.
  - FIFO is empty: word_valid=0, word_out=0, fifo_level=0.
  - overflow=0, abort=0, word_count=0.
- FSM states: IDLE, SHIFT.
  - IDLE to SHIFT when data_logging=1. The bit present on that cycle is sampled as bit 0 of the word.
  - SHIFT stays in SHIFT while data_logging=1.
  - SHIFT to IDLE when data_logging=0.
- Shifting:
  - Each cycle with data_logging=1, serial_in is shifted into the shift register per MSB_FIRST, and bit_cnt increments.
  - bit_cnt runs 0..WORD_W-1 and wraps to 0 on the edge that samples the last bit.
- Word completion:
  - On the edge sampling the bit with bit_cnt=WORD_W-1, the full word (including that bit) is pushed to the FIFO.
  - word_valid rises in the next cycle if the FIFO was empty. Latency is 1 clock from the last serial bit to word_valid.
  - Back-to-back words need no gap. Continuous data_logging yields one word every WORD_W cycles.
- Abort:
  - data_logging falls while in SHIFT with bit_cnt != 0: the partial word is discarded, bit_cnt is cleared to 0, and abort is set.
  - data_logging falls with bit_cnt == 0 (word boundary): no abort.
- FIFO:
  - Show-ahead: word_out always reflects the head entry; it is 0 when empty.
  - Pop happens on word_valid && word_ready.
  - Push to a full FIFO with no simultaneous pop: the word is dropped, overflow is set, word_count is unchanged.
  - Full FIFO with push and pop in the same cycle: both succeed and the level is unchanged.
  - Empty FIFO with push: level becomes 1. The word is not bypassed to the output in the same cycle.
  - word_ready while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- word_count: increments on each successful push; holds at 2^CNT_W-1.
- clear_status:
  - Clears overflow, abort and word_count; it does not touch FIFO contents or the shifter.
  - A set event in the same cycle as clear wins (flag ends set; count ends at 1).
- Reset mid-operation: the async reset drops all FIFO contents and any partial word immediately; outputs return to their reset values.

Decomposition:
- Shared include/package sipo_defs:
  - FSM state encodings (IDLE=1'b0, SHIFT=1'b1).
  - default WORD_W.
  - the clog2 helper function.
- Sub-module sipo_fifo:
  - Parameterised synchronous FIFO (DEPTH, WIDTH) with push/pop, full/empty and level.
  - Async active-low reset.
  - Instantiated once.
- Shifter, bit counter, FSM and status flags stay in the top.

Test Plan:
1. WORD_W=16, MSB_FIRST=1; hold data_logging 16 cycles, serial pattern of 0xA5C3 MSB first -> word_valid rises on cycle 17, word_out=0xA5C3, word_count=1, abort=0.
2. MSB_FIRST=0, same bit stream -> word_out=0xC3A5 (bit-reversed), 1-cycle latency.
3. word_ready=0, log 5 consecutive words 0x0001..0x0005 (80 cycles) -> fifo_level=4, overflow=1, word_count=4; then ready=1 -> pops 0x0001..0x0004 in order, word 5 absent.
4. data_logging high 7 cycles then low -> abort=1, no push, bit_cnt=0; next 16-bit run of 0xFFFF -> word_out=0xFFFF (no stale bits).
5. FIFO full; on the cycle word 5 completes, word_ready=1 -> pop and push both succeed, level stays 4, overflow=0, word_count=5.
6. Assert reset_b low mid-word with 2 words buffered -> word_valid=0, fifo_level=0 and all flags 0 immediately (asynchronously), before the next clk edge; clear_status pulse with word_count=3 -> word_count=0, flags 0.
